// File: rtl/jk_drv_pkg.sv
// jk_drv_pkg: shared state type and 2-bit JK excitation codes for the bank driver.
package jk_drv_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] RST0 = 2'b01;
    localparam logic [1:0] SET1 = 2'b10;
    localparam logic [1:0] TOG  = 2'b11;
    localparam int RETRY_W = 3;
endpackage

// File: rtl/jk_excite.sv
// jk_excite: combinational {J,K} code that moves one JK flop from q to t.
module jk_excite
    import jk_drv_pkg::*;
(
    input  logic q,
    input  logic t,
    input  logic toggle_mode,
    output logic j,
    output logic k
);
    always_comb begin
        {j, k} = (q == t) ? HOLD : toggle_mode ? TOG : t ? SET1 : RST0;
    end
endmodule

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives a bank of external JK flops toward a target word,
// verifies via Q feedback and re-drives up to MAX_RETRY times before flagging ERR.
module jk_bank_driver
    import jk_drv_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter bit TOGGLE_MODE = 1'b0,
    parameter int MAX_RETRY   = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             TGT_VALID,
    output logic             TGT_READY,
    input  logic [WIDTH-1:0] TGT_DATA,
    input  logic [WIDTH-1:0] Q_FB,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             DONE,
    output logic             ERR,
    output logic [WIDTH-1:0] ERR_MASK
);
    localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRY);

    state_t state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d, j_q, j_d, k_q, k_d, mask_q, mask_d;
    logic [WIDTH-1:0] t_sel, j_x, k_x;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic done_q, done_d, err_q, err_d;

    // On accept the code is computed against the incoming word; on retry against the held target.
    assign t_sel = (state_q == IDLE) ? TGT_DATA : tgt_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_exc
        jk_excite u_exc (
            .q(Q_FB[i]),
            .t(t_sel[i]),
            .toggle_mode(TOGGLE_MODE),
            .j(j_x[i]),
            .k(k_x[i])
        );
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        retry_d = retry_q;
        j_d     = '0;
        k_d     = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        mask_d  = '0;
        case (state_q)
            IDLE: begin
                if (TGT_VALID) begin
                    tgt_d   = TGT_DATA;
                    j_d     = j_x;
                    k_d     = k_x;
                    state_d = DRIVE;
                end
            end
            DRIVE: state_d = CHECK;
            CHECK: begin
                if (Q_FB == tgt_q) begin
                    done_d  = 1'b1;
                    retry_d = '0;
                    state_d = IDLE;
                end else if (retry_q < MAX_R) begin
                    retry_d = retry_q + {{(RETRY_W-1){1'b0}}, retry_q != '1};
                    j_d     = j_x;
                    k_d     = k_x;
                    state_d = DRIVE;
                end else begin
                    err_d   = 1'b1;
                    mask_d  = Q_FB ^ tgt_q;
                    retry_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            retry_q <= '0;
            j_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            retry_q <= retry_d;
            j_q     <= j_d;
            k_q     <= k_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

    assign TGT_READY = (state_q == IDLE);
    assign J         = j_q;
    assign K         = k_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign ERR_MASK  = mask_q;
endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: two drivers (set/reset and toggle mode) each closing the loop through a
// modelled JK flop bank with optional stuck-at-0 bits, checked every cycle against a transaction-level predictor.
module tb_jk_bank_driver;
    localparam int MAXR = 2;

    typedef struct packed {
        logic       rdy;
        logic [3:0] j;
        logic [3:0] k;
        logic       done;
        logic       err;
        logic [3:0] mask;
    } exp_t;

    localparam exp_t IDLE_E = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tgt_valid = 1'b0;
    logic [3:0] tgt_data = '0;
    logic [3:0] stuck = '0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] exc(input logic [3:0] q, input logic [3:0] t, input bit tm);
        return tm ? {q ^ t, q ^ t} : {~q & t, q & ~t};
    endfunction

    function automatic logic [3:0] bank_next(input logic [3:0] q, input logic [3:0] j,
                                             input logic [3:0] k, input logic [3:0] s);
        return ((j & ~q) | (~k & q)) & ~s;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam bit TM = (g == 1);
        logic rdy, done, err;
        logic [3:0] j, k, mask;
        logic [3:0] q = '0;
        logic [3:0] qd, qc, jj, kk;
        exp_t cur = IDLE_E;
        exp_t act, e;
        exp_t sched[$];

        jk_bank_driver #(.WIDTH(4), .TOGGLE_MODE(TM), .MAX_RETRY(MAXR)) dut (
            .CLK(clk), .RST(rst), .TGT_VALID(tgt_valid), .TGT_READY(rdy),
            .TGT_DATA(tgt_data), .Q_FB(q), .J(j), .K(k),
            .DONE(done), .ERR(err), .ERR_MASK(mask)
        );

        // Predict the whole transaction at accept: drive/check pairs until the bank matches or attempts run out.
        always @(posedge clk) begin
            if (rst) begin
                sched.delete();
                cur = IDLE_E;
            end else if (cur.rdy && tgt_valid) begin
                qd = q;
                qc = bank_next(q, 4'h0, 4'h0, stuck);
                for (int a = 0; a <= MAXR; a++) begin
                    {jj, kk} = exc(qd, tgt_data, TM);
                    sched.push_back('{1'b0, jj, kk, 1'b0, 1'b0, 4'h0});
                    qc = bank_next(qc, jj, kk, stuck);
                    sched.push_back('{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0});
                    if (qc == tgt_data) begin
                        sched.push_back('{1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0});
                        break;
                    end
                    if (a == MAXR) sched.push_back('{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, qc ^ tgt_data});
                    qd = qc;
                    qc = bank_next(qc, 4'h0, 4'h0, stuck);
                end
                cur = sched.pop_front();
            end else begin
                cur = (sched.size() != 0) ? sched.pop_front() : IDLE_E;
            end
            q <= bank_next(q, j, k, stuck);
        end

        always @(negedge clk) begin
            e = rst ? IDLE_E : cur;
            act = '{rdy, j, k, done, err, mask};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL cycle_inst%0d t=%0t got rdy=%b j=%b k=%b done=%b err=%b mask=%b want rdy=%b j=%b k=%b done=%b err=%b mask=%b",
                         g, $time, act.rdy, act.j, act.k, act.done, act.err, act.mask,
                         e.rdy, e.j, e.k, e.done, e.err, e.mask);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        tgt_valid = 1'b0;
        while (!(inst[0].rdy && inst[1].rdy) && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 30) begin
            errors++;
            $display("FAIL idle_timeout got busy after %0d cycles want ready", n);
        end
    endtask

    initial begin
        int drives, n_done, n_err;
        logic [3:0] err_mask;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_ready", {3'b0, inst[0].rdy}, 4'b0001);
        chk("reset_j", inst[0].j, 4'b0000);
        tick();
        rst = 1'b0;

        // Set/reset codes from 0000 to 1010; DONE two cycles after accept.
        tgt_data = 4'b1010; tgt_valid = 1'b1;
        tick(); tgt_valid = 1'b0;
        @(negedge clk);
        chk("t1_j", inst[0].j, 4'b1010);
        chk("t1_k", inst[0].k, 4'b0000);
        tick(); tick();
        @(negedge clk);
        chk("t1_done", {3'b0, inst[0].done}, 4'b0001);
        chk("t1_q", inst[0].q, 4'b1010);

        // Toggle mode from 1010 to 0110.
        tgt_data = 4'b0110; tgt_valid = 1'b1;
        tick(); tgt_valid = 1'b0;
        @(negedge clk);
        chk("t2_j", inst[1].j, 4'b1100);
        chk("t2_k", inst[1].k, 4'b1100);
        chk("t2_setrst_j", inst[0].j, 4'b0100);
        tick(); tick();
        @(negedge clk);
        chk("t2_done", {3'b0, inst[1].done}, 4'b0001);
        chk("t2_q", inst[1].q, 4'b0110);

        // Target already present, with VALID held through the busy cycles.
        tgt_data = 4'b0101; tgt_valid = 1'b1;
        tick(); tgt_valid = 1'b0;
        tick(); tick();
        tgt_data = 4'b0101; tgt_valid = 1'b1;
        tick();
        @(negedge clk);
        chk("t4_j", inst[0].j, 4'b0000);
        chk("t4_k", inst[1].k, 4'b0000);
        tick();
        @(negedge clk);
        chk("t4_check_not_ready", {3'b0, inst[0].rdy}, 4'b0000);
        tick();
        @(negedge clk);
        chk("t4_done", {3'b0, inst[0].done}, 4'b0001);
        tick(); tgt_valid = 1'b0;
        @(negedge clk);
        chk("t4_reaccepted", {3'b0, inst[0].rdy}, 4'b0000);
        wait_idle();

        // Bit 0 stuck at 0: three drive phases then ERR.
        tgt_data = 4'b0000; tgt_valid = 1'b1;
        tick();
        wait_idle();
        stuck = 4'b0001;
        tick();
        tgt_data = 4'b0001; tgt_valid = 1'b1;
        tick(); tgt_valid = 1'b0;
        drives = 0; n_done = 0; n_err = 0; err_mask = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ((inst[0].j | inst[0].k) != 4'b0) drives++;
            if (inst[0].done) n_done++;
            if (inst[0].err) begin n_err++; err_mask = inst[0].mask; end
            tick();
        end
        chk("t3_drives", 4'(drives), 4'd3);
        chk("t3_err", 4'(n_err), 4'd1);
        chk("t3_no_done", 4'(n_done), 4'd0);
        chk("t3_mask", err_mask, 4'b0001);
        wait_idle();
        stuck = 4'b0000;
        tick();

        // Reset during DRIVE aborts silently.
        tgt_data = 4'b1111; tgt_valid = 1'b1;
        tick(); tgt_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("t5_j", inst[0].j, 4'b0000);
        chk("t5_k", inst[1].k, 4'b0000);
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_ready", {3'b0, inst[0].rdy}, 4'b0001);
        chk("t5_quiet", {2'b0, inst[0].done, inst[0].err}, 4'b0000);
        tick();

        // Random traffic with occasional resets and stuck-bit changes between transactions.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            tgt_valid = $urandom_range(0, 1) == 1;
            tgt_data = 4'($urandom_range(0, 15));
            if (i % 80 == 79) begin
                rst = 1'b0;
                wait_idle();
                stuck = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            end
            tick();
        end
        rst = 1'b0;
        wait_idle();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
